// File: rtl/color_scan_sequencer.sv
// Colour-sensor scan sequencer: walks the photodiode filters, runs one measurement
// handshake per channel and publishes a coherent RGB(C) frame with a valid strobe.
module color_scan_sequencer #(
  parameter int CNT_W       = 25,
  parameter int SETTLE_CYC  = 50000,
  parameter int TIMEOUT_CYC = 25000000,
  parameter int USE_CLEAR   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             single,
  output logic             busy,
  output logic             s2,
  output logic             s3,
  output logic             oe_n,
  output logic [1:0]       channel,
  output logic             meas_start,
  input  logic             meas_done,
  input  logic [CNT_W-1:0] meas_count,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] green,
  output logic [CNT_W-1:0] blue,
  output logic [CNT_W-1:0] clear,
  output logic             frame_valid,
  output logic             timeout_err
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       LAST_CH  = (USE_CLEAR != 0) ? 2'd3 : 2'd2;

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, NEXT, PUBLISH} state_t;

  // Filter select {s2,s3} for a channel index: red, blue, green, clear.
  function automatic logic [1:0] sel_of(input logic [1:0] ch);
    logic [1:0] sel;
    case (ch)
      2'd0:    sel = 2'b00;
      2'd1:    sel = 2'b01;
      2'd2:    sel = 2'b11;
      default: sel = 2'b10;
    endcase
    return sel;
  endfunction

  state_t                    state_q, state_d;
  logic [1:0]                channel_q, channel_d;
  logic                      s2_q, s2_d, s3_q, s3_d;
  logic                      oe_n_q, oe_n_d;
  logic                      busy_q, busy_d;
  logic                      meas_start_q, meas_start_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      timeout_err_q, timeout_err_d;
  logic                      frame_to_q, frame_to_d;
  logic [SET_W-1:0]          settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic [3:0][CNT_W-1:0]     shadow_q, shadow_d;
  logic [CNT_W-1:0]          red_q, red_d, green_q, green_d;
  logic [CNT_W-1:0]          blue_q, blue_d, clear_q, clear_d;

  always_comb begin
    state_d       = state_q;
    channel_d     = channel_q;
    s2_d          = s2_q;
    s3_d          = s3_q;
    oe_n_d        = oe_n_q;
    busy_d        = busy_q;
    meas_start_d  = 1'b0;
    frame_valid_d = 1'b0;
    timeout_err_d = timeout_err_q;
    frame_to_d    = frame_to_q;
    settle_cnt_d  = settle_cnt_q;
    to_cnt_d      = to_cnt_q;
    shadow_d      = shadow_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    clear_d       = clear_q;

    case (state_q)
      IDLE: begin
        if (enable || single) begin
          state_d       = SETTLE;
          channel_d     = 2'd0;
          {s2_d, s3_d}  = 2'b00;
          oe_n_d        = 1'b0;
          busy_d        = 1'b1;
          frame_to_d    = 1'b0;
          settle_cnt_d  = '0;
        end
      end

      SETTLE: begin
        if (settle_cnt_q == SET_LAST) begin
          state_d      = MEASURE;
          meas_start_d = 1'b1;
          settle_cnt_d = '0;
          to_cnt_d     = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end

      MEASURE: begin
        // A done arriving together with our own start pulse belongs to nothing we asked for.
        if (meas_done && !meas_start_q) begin
          shadow_d[channel_q] = meas_count;
          state_d             = NEXT;
        end else if (to_cnt_q == TO_LAST) begin
          shadow_d[channel_q] = '1;
          frame_to_d          = 1'b1;
          state_d             = NEXT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      NEXT: begin
        if (channel_q == LAST_CH) begin
          state_d       = PUBLISH;
          red_d         = shadow_q[0];
          blue_d        = shadow_q[1];
          green_d       = shadow_q[2];
          clear_d       = (USE_CLEAR != 0) ? shadow_q[3] : '0;
          frame_valid_d = 1'b1;
          timeout_err_d = frame_to_q;
        end else begin
          state_d      = SETTLE;
          channel_d    = channel_q + 2'd1;
          {s2_d, s3_d} = sel_of(channel_q + 2'd1);
          settle_cnt_d = '0;
        end
      end

      PUBLISH: begin
        channel_d    = 2'd0;
        {s2_d, s3_d} = 2'b00;
        settle_cnt_d = '0;
        if (enable) begin
          state_d    = SETTLE;
          frame_to_d = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          oe_n_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      channel_q     <= 2'd0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      oe_n_q        <= 1'b1;
      busy_q        <= 1'b0;
      meas_start_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_to_q    <= 1'b0;
      settle_cnt_q  <= '0;
      to_cnt_q      <= '0;
      shadow_q      <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      clear_q       <= '0;
    end else begin
      state_q       <= state_d;
      channel_q     <= channel_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      oe_n_q        <= oe_n_d;
      busy_q        <= busy_d;
      meas_start_q  <= meas_start_d;
      frame_valid_q <= frame_valid_d;
      timeout_err_q <= timeout_err_d;
      frame_to_q    <= frame_to_d;
      settle_cnt_q  <= settle_cnt_d;
      to_cnt_q      <= to_cnt_d;
      shadow_q      <= shadow_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      clear_q       <= clear_d;
    end
  end

  assign busy        = busy_q;
  assign s2          = s2_q;
  assign s3          = s3_q;
  assign oe_n        = oe_n_q;
  assign channel     = channel_q;
  assign meas_start  = meas_start_q;
  assign frame_valid = frame_valid_q;
  assign timeout_err = timeout_err_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign clear       = clear_q;

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Directed bench for color_scan_sequencer: an RGB-only and an RGBC instance share
// clock and reset, each answered by a small frequency-unit responder.
module tb_color_scan_sequencer;

  localparam int CW = 25;
  localparam int SC = 4;
  localparam int TO = 20;
  localparam logic [CW-1:0] ALL1 = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en [2] = '{1'b0, 1'b0};
  logic sg [2] = '{1'b0, 1'b0};
  logic man_done [2] = '{1'b0, 1'b0};
  logic [CW-1:0] man_cnt [2] = '{'0, '0};
  logic auto_done [2] = '{1'b0, 1'b0};
  logic [CW-1:0] auto_cnt [2] = '{'0, '0};
  logic done_w [2];
  logic [CW-1:0] cnt_w [2];

  logic busy_w [2], s2_w [2], s3_w [2], oe_w [2], ms_w [2], fv_w [2], te_w [2];
  logic [1:0] ch_w [2];
  logic [CW-1:0] red_w [2], green_w [2], blue_w [2], clear_w [2];

  assign done_w[0] = auto_done[0] | man_done[0];
  assign done_w[1] = auto_done[1] | man_done[1];
  assign cnt_w[0]  = man_done[0] ? man_cnt[0] : auto_cnt[0];
  assign cnt_w[1]  = man_done[1] ? man_cnt[1] : auto_cnt[1];

  color_scan_sequencer #(.CNT_W(CW), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO), .USE_CLEAR(0)) dut0 (
    .clk(clk), .rst(rst), .enable(en[0]), .single(sg[0]), .busy(busy_w[0]),
    .s2(s2_w[0]), .s3(s3_w[0]), .oe_n(oe_w[0]), .channel(ch_w[0]),
    .meas_start(ms_w[0]), .meas_done(done_w[0]), .meas_count(cnt_w[0]),
    .red(red_w[0]), .green(green_w[0]), .blue(blue_w[0]), .clear(clear_w[0]),
    .frame_valid(fv_w[0]), .timeout_err(te_w[0])
  );

  color_scan_sequencer #(.CNT_W(CW), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO), .USE_CLEAR(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .single(sg[1]), .busy(busy_w[1]),
    .s2(s2_w[1]), .s3(s3_w[1]), .oe_n(oe_w[1]), .channel(ch_w[1]),
    .meas_start(ms_w[1]), .meas_done(done_w[1]), .meas_count(cnt_w[1]),
    .red(red_w[1]), .green(green_w[1]), .blue(blue_w[1]), .clear(clear_w[1]),
    .frame_valid(fv_w[1]), .timeout_err(te_w[1])
  );

  // Responder: done one cycle after start, count = base + (channel+1)*100,
  // except on the channel listed in skip_ch which never answers.
  int   resp_base [2] = '{0, 0};
  int   skip_ch [2]   = '{-1, -1};
  bit   resp_on [2]   = '{1'b1, 1'b1};
  bit   pend [2]      = '{1'b0, 1'b0};
  logic [CW-1:0] pval [2] = '{'0, '0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      auto_done[d] = 1'b0;
      if (pend[d]) begin
        auto_done[d] = 1'b1;
        auto_cnt[d]  = pval[d];
        pend[d]      = 1'b0;
      end
      if (resp_on[d] && ms_w[d] && int'(ch_w[d]) != skip_ch[d]) begin
        pend[d] = 1'b1;
        pval[d] = CW'(resp_base[d] + (int'(ch_w[d]) + 1) * 100);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Pulse single and follow the frame until frame_valid (sampled at negedges).
  task automatic run_single(input int d, output int lat, output logic [7:0] sseq,
                            output logic [7:0] cseq, output bit ok);
    sseq = '0; cseq = '0; lat = 0; ok = 1'b0;
    @(negedge clk);
    sg[d] = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) sg[d] = 1'b0;
      if (ms_w[d]) begin
        sseq = {sseq[5:0], s2_w[d], s3_w[d]};
        cseq = {cseq[5:0], ch_w[d]};
      end
      if (fv_w[d]) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fv(input int d, input int maxc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (fv_w[d]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int            dsel;
    int            skip;
    int            base;
    logic [CW-1:0] r, b, g, c;
    logic          te;
    int            lat;
    logic [7:0]    sel_seq;
    logic [7:0]    ch_seq;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int d, lat, frames, gap, idle_cyc, fv_cnt;
    logic [7:0] sseq, cseq;
    logic [CW-1:0] prev_red;
    bit ok, dropped;

    tbl[0] = '{0, -1, 0, 25'd100, 25'd200, 25'd300, 25'd0,   1'b0, 22, 8'h07, 8'h06};
    tbl[1] = '{0,  1, 0, 25'd100, ALL1,    25'd300, 25'd0,   1'b1, 40, 8'h07, 8'h06};
    tbl[2] = '{0, -1, 5, 25'd105, 25'd205, 25'd305, 25'd0,   1'b0, 22, 8'h07, 8'h06};
    tbl[3] = '{1, -1, 0, 25'd100, 25'd200, 25'd300, 25'd400, 1'b0, 29, 8'h1E, 8'h1B};
    tbl[4] = '{1,  3, 0, 25'd100, 25'd200, 25'd300, ALL1,    1'b1, 47, 8'h1E, 8'h1B};
    tbl[5] = '{1,  0, 7, ALL1,    25'd207, 25'd307, 25'd407, 1'b1, 47, 8'h1E, 8'h1B};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d busy", k), busy_w[k], 0);
      check($sformatf("rst%0d oe_n", k), oe_w[k], 1);
      check($sformatf("rst%0d sel", k), {s2_w[k], s3_w[k], ch_w[k]}, 0);
      check($sformatf("rst%0d ms/fv/te", k), {ms_w[k], fv_w[k], te_w[k]}, 0);
      check($sformatf("rst%0d red", k), red_w[k], 0);
    end
    rst = 1'b0;

    // Single-shot frames from the table
    for (int i = 0; i < 6; i++) begin
      d = tbl[i].dsel;
      skip_ch[d]   = tbl[i].skip;
      resp_base[d] = tbl[i].base;
      run_single(d, lat, sseq, cseq, ok);
      check($sformatf("v%0d frame_seen", i), ok, 1);
      check($sformatf("v%0d latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d sel_seq", i), sseq, tbl[i].sel_seq);
      check($sformatf("v%0d ch_seq", i), cseq, tbl[i].ch_seq);
      check($sformatf("v%0d red", i), red_w[d], tbl[i].r);
      check($sformatf("v%0d blue", i), blue_w[d], tbl[i].b);
      check($sformatf("v%0d green", i), green_w[d], tbl[i].g);
      check($sformatf("v%0d clear", i), clear_w[d], tbl[i].c);
      check($sformatf("v%0d timeout_err", i), te_w[d], tbl[i].te);
      check($sformatf("v%0d busy/oe at fv", i), {busy_w[d], oe_w[d]}, 2'b10);
      @(negedge clk);
      check($sformatf("v%0d busy/oe after", i), {busy_w[d], oe_w[d]}, 2'b01);
      check($sformatf("v%0d fv one cycle", i), fv_w[d], 0);
      skip_ch[d] = -1;
    end

    // Continuous mode, RGBC: three back-to-back frames, enable dropped in frame 3
    resp_base[1] = 10;
    frames = 0; gap = 0; idle_cyc = 0; sseq = '0; prev_red = '0;
    @(negedge clk);
    en[1] = 1'b1;
    for (int n = 1; n <= 400 && frames < 3; n++) begin
      @(negedge clk);
      if (!busy_w[1]) idle_cyc++;
      if (ms_w[1]) sseq = {sseq[5:0], s2_w[1], s3_w[1]};
      if (fv_w[1]) begin
        frames++;
        check($sformatf("en f%0d red", frames), red_w[1], 10 * frames + 100);
        check($sformatf("en f%0d blue", frames), blue_w[1], 10 * frames + 200);
        check($sformatf("en f%0d green", frames), green_w[1], 10 * frames + 300);
        check($sformatf("en f%0d clear", frames), clear_w[1], 10 * frames + 400);
        check($sformatf("en f%0d sel_seq", frames), sseq, 8'h1E);
        check($sformatf("en f%0d timeout_err", frames), te_w[1], 0);
        if (frames > 1) begin
          check($sformatf("en f%0d gap", frames), gap, 29);
          check($sformatf("en f%0d held red", frames), prev_red, 10 * (frames - 1) + 100);
        end
        sseq = '0;
        gap  = 0;
        resp_base[1] += 10;
      end else begin
        prev_red = red_w[1];
        if (frames == 2 && gap == 5) en[1] = 1'b0;
      end
      gap++;
    end
    check("en frames", frames, 3);
    check("en idle cycles", idle_cyc, 0);
    @(negedge clk);
    check("en busy/oe after", {busy_w[1], oe_w[1]}, 2'b01);

    // Enable dropped during green SETTLE, single pulsed while busy
    resp_base[0] = 20;
    dropped = 1'b0; fv_cnt = 0;
    @(negedge clk);
    en[0] = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      sg[0] = 1'b0;
      if (!dropped && busy_w[0] && ch_w[0] == 2'd2 && !ms_w[0]) begin
        dropped = 1'b1;
        en[0]   = 1'b0;
        sg[0]   = 1'b1;
      end
      if (fv_w[0]) begin
        fv_cnt++;
        check("drop red", red_w[0], 120);
        check("drop green", green_w[0], 320);
      end
    end
    check("drop frames", fv_cnt, 1);
    check("drop idle busy/oe", {busy_w[0], oe_w[0]}, 2'b01);

    // Spurious done in SETTLE and done coincident with meas_start
    resp_base[0] = 0;
    resp_on[0]   = 1'b0;
    @(negedge clk);
    sg[0] = 1'b1;
    @(negedge clk);
    sg[0] = 1'b0;
    man_cnt[0]  = 25'h11;
    man_done[0] = 1'b1;
    @(negedge clk);
    man_done[0] = 1'b0;
    ok = 1'b0;
    lat = 2;
    for (int n = 0; n < 50; n++) begin
      if (ms_w[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check("spur start seen", ok, 1);
    check("spur start cycle", lat, 5);
    man_cnt[0]  = 25'h22;
    man_done[0] = 1'b1;
    @(negedge clk);
    man_cnt[0]  = 25'h33;
    @(negedge clk);
    man_done[0] = 1'b0;
    resp_on[0]  = 1'b1;
    wait_fv(0, 100, ok);
    check("spur frame seen", ok, 1);
    check("spur red", red_w[0], 25'h33);
    check("spur blue", blue_w[0], 200);
    check("spur green", green_w[0], 300);
    check("spur timeout_err", te_w[0], 0);
    @(negedge clk);

    // Asynchronous reset in the middle of a measurement
    @(negedge clk);
    sg[0] = 1'b1;
    @(negedge clk);
    sg[0] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (ms_w[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid rst start seen", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("mid rst busy/oe", {busy_w[0], oe_w[0]}, 2'b01);
    check("mid rst ms/fv", {ms_w[0], fv_w[0]}, 0);
    check("mid rst sel", {s2_w[0], s3_w[0], ch_w[0]}, 0);
    check("mid rst red", red_w[0], 0);
    @(negedge clk);
    rst = 1'b0;
    fv_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (fv_w[0] || busy_w[0]) fv_cnt++;
    end
    check("post rst stays idle", fv_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
